// File: rtl/fb_blitter_pkg.sv
// fb_blitter_pkg: shared constants for the framebuffer fill blitter.
//   - register byte offsets inside the six-word register window
//   - CTRL bit indices (write: START/DONE_CLR/IRQ_EN, read: BUSY/DONE/IRQ_EN)
//   - FSM state enum
package fb_blitter_pkg;

  localparam logic [4:0]  OFF_DST    = 5'h00;
  localparam logic [4:0]  OFF_WIDTH  = 5'h04;
  localparam logic [4:0]  OFF_HEIGHT = 5'h08;
  localparam logic [4:0]  OFF_STRIDE = 5'h0C;
  localparam logic [4:0]  OFF_COLOR  = 5'h10;
  localparam logic [4:0]  OFF_CTRL   = 5'h14;
  localparam logic [31:0] WIN_BYTES  = 32'd24;

  // CTRL write bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_DONE   = 1;  // write 1 clears DONE, read returns DONE
  localparam int CTRL_IRQ_EN = 2;
  // CTRL read bits (DONE and IRQ_EN share the write positions)
  localparam int CTRL_BUSY   = 0;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

endpackage

// File: rtl/fb_blitter_regs.sv
// fb_blitter_regs: register file and combinational read mux of the blitter.
// Optional feature: FB_BLITTER_IRQ_EN implements the IRQ_EN bit and a
// registered irq = DONE && IRQ_EN; otherwise irq is tied low.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   bus_addr/wdata/we     CPU store port; bus_rdata combinational read data
//   busy                  FSM is in RUN (locks config and start)
//   start_ack             a start was accepted (clears DONE)
//   done_set              fill finished or empty start (sets DONE)
//   start_req             decoded start request, already gated by !busy
//   dst..color            configuration registers to the FSM
//   irq                   completion interrupt
module fb_blitter_regs
  import fb_blitter_pkg::*;
#(
  parameter logic [31:0] REG_BASE = 32'h0000_2000,
  parameter int          DIM_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  input  logic             bus_we,
  output logic [31:0]      bus_rdata,
  input  logic             busy,
  input  logic             start_ack,
  input  logic             done_set,
  output logic             start_req,
  output logic [31:0]      dst,
  output logic [DIM_W-1:0] width,
  output logic [DIM_W-1:0] height,
  output logic [15:0]      stride,
  output logic [31:0]      color,
  output logic             irq
);

  logic [31:0] off;
  logic        in_win;
  logic        cfg_we;
  logic        ctrl_we;
  logic        done_q;
  logic        irq_en;

  // Unsigned subtract: addresses below the base wrap to huge offsets and
  // fall outside the window.
  assign off     = bus_addr - REG_BASE;
  assign in_win  = off < WIN_BYTES;
  assign cfg_we  = bus_we && in_win && !busy;
  assign ctrl_we = bus_we && in_win && (off[4:0] == OFF_CTRL);

  assign start_req = ctrl_we && bus_wdata[CTRL_START] && !busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      dst    <= '0;
      width  <= '0;
      height <= '0;
      stride <= '0;
      color  <= '0;
    end else if (cfg_we) begin
      case (off[4:0])
        OFF_DST:    dst    <= {bus_wdata[31:2], 2'b00};
        OFF_WIDTH:  width  <= bus_wdata[DIM_W-1:0];
        OFF_HEIGHT: height <= bus_wdata[DIM_W-1:0];
        OFF_STRIDE: stride <= bus_wdata[15:0];
        OFF_COLOR:  color  <= bus_wdata;
        default: ;
      endcase
    end
  end

  // Completion beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)
      done_q <= 1'b0;
    else if (done_set)
      done_q <= 1'b1;
    else if ((ctrl_we && bus_wdata[CTRL_DONE]) || start_ack)
      done_q <= 1'b0;
  end

`ifdef FB_BLITTER_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_we)
        irq_en <= bus_wdata[CTRL_IRQ_EN];
      irq <= done_q && irq_en;
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    bus_rdata = '0;
    if (in_win) begin
      case (off[4:0])
        OFF_DST:    bus_rdata = dst;
        OFF_WIDTH:  bus_rdata = {{(32-DIM_W){1'b0}}, width};
        OFF_HEIGHT: bus_rdata = {{(32-DIM_W){1'b0}}, height};
        OFF_STRIDE: bus_rdata = {16'h0, stride};
        OFF_COLOR:  bus_rdata = color;
        OFF_CTRL: begin
          bus_rdata[CTRL_BUSY]   = busy;
          bus_rdata[CTRL_DONE]   = done_q;
          bus_rdata[CTRL_IRQ_EN] = irq_en;
        end
        default: bus_rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/fb_blitter.sv
// fb_blitter: rectangular solid-colour fill engine for the framebuffer.
// Writes COLOR to WIDTH words per row for HEIGHT rows starting at DST,
// advancing STRIDE bytes between row starts. One word per granted beat.
// Optional feature: FB_BLITTER_IRQ_EN (see fb_blitter_regs).
// Ports:
//   clk, reset            clock (CLOCK_50 domain), synchronous active-high reset
//   bus_addr/wdata/we     CPU register store port; bus_rdata read data
//   mem_addr/wdata/we/be  framebuffer write request; mem_gnt accepts a beat
//   irq                   completion interrupt
module fb_blitter
  import fb_blitter_pkg::*;
#(
  parameter logic [31:0] REG_BASE = 32'h0000_2000,
  parameter int          DIM_W    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  output logic [31:0] bus_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  output logic        irq
);

  state_e           state_q, state_d;
  logic [31:0]      cur_q, row_base_q, next_row;
  logic [DIM_W-1:0] col_q, row_q;
  logic [31:0]      dst, color;
  logic [DIM_W-1:0] width, height;
  logic [15:0]      stride;
  logic             busy, start_req, start_ok, done_set, beat;
  logic             last_col, last_row;

  fb_blitter_regs #(.REG_BASE(REG_BASE), .DIM_W(DIM_W)) u_regs (
    .clk       (clk),
    .reset     (reset),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata),
    .busy      (busy),
    .start_ack (start_ok),
    .done_set  (done_set),
    .start_req (start_req),
    .dst       (dst),
    .width     (width),
    .height    (height),
    .stride    (stride),
    .color     (color),
    .irq       (irq)
  );

  assign busy      = (state_q == RUN);
  // Config is frozen during RUN, so WIDTH/HEIGHT are nonzero here.
  assign last_col  = (col_q == width  - DIM_W'(1));
  assign last_row  = (row_q == height - DIM_W'(1));
  assign next_row  = row_base_q + {16'h0, stride};
  // COLOR cannot change during RUN, so it drives the data bus directly.
  assign mem_wdata = color;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    done_set = 1'b0;
    beat     = 1'b0;
    mem_we   = 1'b0;
    mem_be   = 4'h0;
    mem_addr = '0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          if (width != '0 && height != '0) begin
            start_ok = 1'b1;
            state_d  = RUN;
          end else begin
            // Empty rectangle: report done without touching memory.
            done_set = 1'b1;
          end
        end
      end
      RUN: begin
        mem_we   = 1'b1;
        mem_be   = 4'hF;
        mem_addr = cur_q;
        beat     = mem_gnt;
        if (beat && last_col && last_row) begin
          done_set = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address generator: cur walks the row, row_base remembers its start.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q      <= '0;
      row_base_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else if (start_ok) begin
      cur_q      <= dst;
      row_base_q <= dst;
      col_q      <= '0;
      row_q      <= '0;
    end else if (beat) begin
      if (!last_col) begin
        col_q <= col_q + DIM_W'(1);
        cur_q <= cur_q + 32'd4;
      end else if (!last_row) begin
        row_q      <= row_q + DIM_W'(1);
        col_q      <= '0;
        row_base_q <= next_row;
        cur_q      <= next_row;
      end
    end
  end

endmodule

// File: tb/tb_fb_blitter.sv
// tb_fb_blitter: self-checking bench for fb_blitter. Table of fill
// vectors checked against a nested-loop address model, plus hand-written
// sequences for mid-run writes, DONE races, irq and reset abort.
module tb_fb_blitter;

  localparam logic [31:0] BASE   = 32'h0000_2000;
  localparam logic [31:0] A_DST  = BASE + 32'h00;
  localparam logic [31:0] A_W    = BASE + 32'h04;
  localparam logic [31:0] A_H    = BASE + 32'h08;
  localparam logic [31:0] A_STR  = BASE + 32'h0C;
  localparam logic [31:0] A_COL  = BASE + 32'h10;
  localparam logic [31:0] A_CTRL = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] bus_addr = A_CTRL;
  logic [31:0] bus_wdata = '0;
  logic        bus_we = 1'b0;
  logic [31:0] bus_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        irq;

  fb_blitter #(.REG_BASE(BASE), .DIM_W(10)) dut (
    .clk(clk), .reset(reset),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_rdata(bus_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .irq(irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Grant generator: 0 = always, 1 = low/high alternating from the first
  // RUN cycle, 2 = random.
  int   gnt_mode = 0;
  logic ph = 1'b0;
  always @(posedge clk) begin
    #1;
    case (gnt_mode)
      0: mem_gnt = 1'b1;
      1: if (!mem_we) begin ph = 1'b0; mem_gnt = 1'b0; end
         else begin mem_gnt = ph; ph = ~ph; end
      default: mem_gnt = 1'($urandom_range(0, 1));
    endcase
  end

  // Write monitor: records accepted requests, checks hold-under-stall.
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  int          we_cycles = 0;
  logic        stall_p = 1'b0;
  logic [31:0] p_addr, p_data;
  always @(negedge clk) begin
    if (mem_we) we_cycles++;
    if (mem_we && mem_gnt) begin
      q_addr.push_back(mem_addr);
      q_data.push_back(mem_wdata);
    end
    if (stall_p) begin
      check("hold_we", 32'(mem_we), 32'd1);
      check("hold_addr", mem_addr, p_addr);
      check("hold_data", mem_wdata, p_data);
    end
    check("mem_be", 32'(mem_be), mem_we ? 32'hF : 32'h0);
    stall_p = mem_we && !mem_gnt;
    p_addr  = mem_addr;
    p_data  = mem_wdata;
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; bus_addr = A_CTRL;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    bus_addr = a;
    #1;
    check(nm, bus_rdata, exp);
    bus_addr = A_CTRL;
  endtask

  // Poll CTRL.DONE; lat counts cycles after the start edge.
  task automatic wait_done(output int lat);
    lat = -1;
    bus_addr = A_CTRL;
    for (int k = 0; k < 400; k++) begin
      #1;
      if (bus_rdata[1]) begin lat = k; break; end
      @(negedge clk);
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] model_addr(input logic [31:0] dst, input logic [31:0] stride,
                                              input int r, input int c);
    return (dst & ~32'h3) + 32'(r) * (stride & 32'hFFFF) + 32'(c) * 32'd4;
  endfunction

  task automatic check_seq(input string nm, input logic [31:0] dst, input logic [31:0] w,
                           input logic [31:0] h, input logic [31:0] stride, input logic [31:0] color);
    int wm, hm, i;
    wm = int'(w & 32'h3FF);
    hm = int'(h & 32'h3FF);
    check({nm, "_count"}, 32'(q_addr.size()), 32'(wm * hm));
    i = 0;
    for (int r = 0; r < hm; r++)
      for (int c = 0; c < wm; c++) begin
        if (i < q_addr.size()) begin
          check({nm, "_addr"}, q_addr[i], model_addr(dst, stride, r, c));
          check({nm, "_data"}, q_data[i], color);
        end
        i++;
      end
  endtask

  task automatic config_fill(input logic [31:0] dst, input logic [31:0] w, input logic [31:0] h,
                             input logic [31:0] stride, input logic [31:0] color);
    wr(A_DST, dst); wr(A_W, w); wr(A_H, h); wr(A_STR, stride); wr(A_COL, color);
  endtask

  typedef struct {
    logic [31:0] dst, w, h, stride, color;
    int          mode;
    int          exp_n;
  } vec_t;
  vec_t vt[10];

  initial begin
    int lat;

    vt[0] = '{32'h100, 4, 2, 32'h40, 32'hAABBCCDD, 0, 8};
    vt[1] = '{32'h100, 4, 2, 32'h40, 32'hAABBCCDD, 1, 8};
    vt[2] = '{32'h0, 0, 5, 32'h0, 32'h12345678, 0, 0};
    vt[3] = '{32'hFFFF_FFF8, 3, 1, 32'h0, 32'h55, 0, 3};
    vt[4] = '{32'h203, 2, 2, 32'hFFFF_0010, 32'h0BAD_F00D, 0, 4};
    vt[5] = '{32'h400, 32'h402, 1, 32'h0, 32'h7, 0, 2};
    vt[6] = '{32'h800, 3, 0, 32'h20, 32'h9, 0, 0};
    for (int v = 7; v < 10; v++) begin
      vt[v].dst = $urandom; vt[v].w = $urandom_range(1, 5); vt[v].h = $urandom_range(1, 4);
      vt[v].stride = $urandom; vt[v].color = $urandom; vt[v].mode = 2;
      vt[v].exp_n = int'(vt[v].w * vt[v].h);
    end

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rd_chk("rst_dst", A_DST, 32'd0);
    rd_chk("rst_width", A_W, 32'd0);
    rd_chk("rst_ctrl", A_CTRL, 32'd0);

    // Register masking and window decode
    wr(A_DST, 32'h1234_5677);
    rd_chk("dst_mask", A_DST, 32'h1234_5674);
    wr(A_STR, 32'hFFFF_FFFF);
    rd_chk("stride_mask", A_STR, 32'h0000_FFFF);
    wr(A_W, 32'hFFFF_FFFF);
    rd_chk("width_mask", A_W, 32'h0000_03FF);
    wr(BASE + 32'h18, 32'hDEAD_BEEF);
    wr(BASE - 32'h4, 32'hDEAD_BEEF);
    rd_chk("outside_no_write", A_DST, 32'h1234_5674);
    rd_chk("outside_read", BASE + 32'h18, 32'd0);

    // Table-driven fills
    for (int v = 0; v < 10; v++) begin
      gnt_mode = vt[v].mode;
      config_fill(vt[v].dst, vt[v].w, vt[v].h, vt[v].stride, vt[v].color);
      q_addr.delete(); q_data.delete(); we_cycles = 0;
      wr(A_CTRL, 32'h1);
      wait_done(lat);
      check_seq($sformatf("vec%0d", v), vt[v].dst, vt[v].w, vt[v].h, vt[v].stride, vt[v].color);
      check($sformatf("vec%0d_n", v), 32'(q_addr.size()), 32'(vt[v].exp_n));
      if (vt[v].mode == 0)      check($sformatf("vec%0d_lat", v), 32'(lat), 32'(vt[v].exp_n));
      else if (vt[v].mode == 1) check($sformatf("vec%0d_cyc", v), 32'(we_cycles), 32'(2 * vt[v].exp_n));
      else                      check($sformatf("vec%0d_latmin", v), 32'(lat >= vt[v].exp_n), 32'd1);
      rd_chk($sformatf("vec%0d_ctrl", v), A_CTRL, 32'h2);
    end

    // Writes and start mid-RUN are ignored
    gnt_mode = 1;
    config_fill(32'h100, 4, 2, 32'h40, 32'hAABBCCDD);
    q_addr.delete(); q_data.delete();
    wr(A_CTRL, 32'h1);
    wr(A_COL, 32'h1);
    wr(A_DST, 32'h0);
    wr(A_W, 32'h9);
    wr(A_CTRL, 32'h1);
    wait_done(lat);
    repeat (6) @(negedge clk);
    check_seq("midrun", 32'h100, 4, 2, 32'h40, 32'hAABBCCDD);
    rd_chk("midrun_width", A_W, 32'd4);
    rd_chk("midrun_ctrl", A_CTRL, 32'h2);

    // DONE-clear in the completion cycle loses; plain clear works
    gnt_mode = 0;
    config_fill(32'h300, 1, 1, 32'h0, 32'h1);
    wr(A_CTRL, 32'h1);
    bus_addr = A_CTRL; bus_wdata = 32'h2; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0;
    rd_chk("clr_race", A_CTRL, 32'h2);
    wr(A_CTRL, 32'h2);
    rd_chk("clr_done", A_CTRL, 32'h0);

`ifdef FB_BLITTER_IRQ_EN
    wr(A_CTRL, 32'h5);
    wait_done(lat);
    check("irq_low_at_done", 32'(irq), 32'd0);
    @(negedge clk); #1;
    check("irq_rise", 32'(irq), 32'd1);
    wr(A_CTRL, 32'h2);
    @(negedge clk); #1;
    check("irq_drop", 32'(irq), 32'd0);
`else
    wr(A_CTRL, 32'h4);
    rd_chk("irq_en_absent", A_CTRL, 32'h0);
    wr(A_CTRL, 32'h1);
    wait_done(lat);
    repeat (2) @(negedge clk);
    #1;
    check("irq_tied", 32'(irq), 32'd0);
`endif

    // Reset mid-fill aborts at once
    gnt_mode = 0;
    config_fill(32'h100, 4, 2, 32'h40, 32'h3);
    q_addr.delete(); q_data.delete();
    wr(A_CTRL, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_addr", mem_addr, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("abort_count", 32'(q_addr.size()), 32'd2);
    rd_chk("abort_ctrl", A_CTRL, 32'h0);
    rd_chk("abort_dst", A_DST, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
